// File: rtl/core_tick_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_tick_sequencer_pkg
// Brief    : Shared state encoding and defaults for the tick sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package core_tick_sequencer_pkg;

    localparam int unsigned DEFAULT_TICK_PERIOD = 100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/core_tick_sequencer_tick_period_counter.sv
`default_nettype none
// ============================================================================
// Module   : tick_period_counter
// Brief    : Saturating cycles-since-tick counter with period-expiry flag.
// Revision : 1.0 - initial release
// ============================================================================
module tick_period_counter
    import core_tick_sequencer_pkg::*;
#(
    parameter int unsigned TICK_PERIOD = DEFAULT_TICK_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned       CNT_W    = $clog2(TICK_PERIOD + 1);
    localparam logic [CNT_W-1:0]  c_period = CNT_W'(TICK_PERIOD);
    localparam logic [CNT_W-1:0]  c_last   = CNT_W'(TICK_PERIOD - 1);

    logic [CNT_W-1:0] r_count;

    // Clear loads 1: the tick cycle itself is the first elapsed cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= CNT_W'(1);
        end else if (i_enable && (r_count != c_period)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Flags the cycle whose edge completes the period, so a registered
    // next-state can place the following tick exactly TICK_PERIOD later.
    assign o_expired = (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/core_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_tick_sequencer
// Brief    : Global time-step sequencer: issues ticks, tracks busy cores,
//            records overruns and never ticks a core that is still busy.
// Revision : 1.0 - initial release
// ============================================================================
module core_tick_sequencer
    import core_tick_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned TICK_PERIOD = DEFAULT_TICK_PERIOD,
    parameter int unsigned TICK_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [TICK_CNT_W-1:0] i_num_ticks,
    input  logic [NUM_CORES-1:0]  i_core_done,
    output logic                  o_tick,
    output logic                  o_running,
    output logic [TICK_CNT_W-1:0] o_tick_index,
    output logic [NUM_CORES-1:0]  o_busy_mask,
    output logic                  o_overrun,
    output logic [NUM_CORES-1:0]  o_overrun_mask,
    output logic                  o_finished
);

    seq_state_t            r_state;
    seq_state_t            w_state_next;

    logic [TICK_CNT_W-1:0] r_latched;
    logic [TICK_CNT_W-1:0] r_tick_index;
    logic [NUM_CORES-1:0]  r_busy_mask;
    logic [NUM_CORES-1:0]  r_overrun_mask;
    logic                  r_running;
    logic                  r_overrun;
    logic                  r_finished;
    logic                  r_stop_pend;
    logic                  r_ovr_seen;

    logic [NUM_CORES-1:0]  w_busy_next;
    logic                  w_stop;
    logic                  w_count_reached;
    logic                  w_expired;
    logic                  w_start_acc;
    logic                  w_finish;
    logic                  w_ovr_event;
    logic                  w_in_issue;

    // Decisions look at busy state after this cycle's done pulses so the
    // next tick can follow the last done by one cycle.
    assign w_busy_next     = r_busy_mask & ~i_core_done;
    assign w_stop          = i_stop | r_stop_pend;
    assign w_count_reached = (r_latched != '0) && (r_tick_index == r_latched);
    assign w_in_issue      = (r_state == ST_ISSUE);

    tick_period_counter #(
        .TICK_PERIOD (TICK_PERIOD)
    ) u_period (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_in_issue),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_finish     = 1'b0;
        w_ovr_event  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_stop) begin
                    if (w_busy_next == '0) begin
                        w_finish     = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DRAIN;
                    end
                end else if (w_expired) begin
                    if (w_busy_next == '0) begin
                        if (w_count_reached) begin
                            w_finish     = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_ISSUE;
                        end
                    end else if (!r_ovr_seen) begin
                        w_ovr_event = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_busy_next == '0) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_latched      <= '0;
            r_tick_index   <= '0;
            r_busy_mask    <= '0;
            r_overrun_mask <= '0;
            r_running      <= 1'b0;
            r_overrun      <= 1'b0;
            r_finished     <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_ovr_seen     <= 1'b0;
        end else begin
            r_finished <= w_finish;

            if (w_start_acc) begin
                r_latched      <= i_num_ticks;
                r_running      <= 1'b1;
                r_tick_index   <= '0;
                r_overrun      <= 1'b0;
                r_overrun_mask <= '0;
            end else if (w_finish) begin
                r_running <= 1'b0;
            end

            if (r_state == ST_IDLE || w_finish) begin
                r_stop_pend <= 1'b0;
            end else if (i_stop) begin
                r_stop_pend <= 1'b1;
            end

            // A same-cycle done loses to the tick's set.
            if (w_in_issue) begin
                r_busy_mask  <= '1;
                r_tick_index <= r_tick_index + TICK_CNT_W'(1);
                r_ovr_seen   <= 1'b0;
            end else begin
                r_busy_mask <= w_busy_next;
                if (w_ovr_event) begin
                    r_ovr_seen <= 1'b1;
                end
            end

            if (w_ovr_event) begin
                r_overrun      <= 1'b1;
                r_overrun_mask <= r_overrun_mask | w_busy_next;
            end
        end
    end

    assign o_tick         = w_in_issue & ~rst;
    assign o_finished     = r_finished & ~rst;
    assign o_running      = r_running;
    assign o_tick_index   = r_tick_index;
    assign o_busy_mask    = r_busy_mask;
    assign o_overrun      = r_overrun;
    assign o_overrun_mask = r_overrun_mask;

endmodule
`default_nettype wire
